// File: rtl/tdc_pkg.sv
// Shared types and constants for the trigger TDC sequencer.
package tdc_pkg;

  localparam int CNT_W_DEF = 32;

  // Bit positions inside res_err.
  localparam int ERR_TO    = 0;
  localparam int ERR_RANGE = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WAIT_RISE,
    WAIT_FALL,
    SETTLE,
    DONE
  } tdc_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, with single-cycle rise/fall pulses
// derived from the synchronized level and its one-cycle delayed copy.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] form the synchronizer; [1] is the safe level, [2] its delayed copy.
  logic [2:0] sr_q;

  // NOTE: registers take non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[1:0], async_i};
    end
  end

  assign rise_o =  sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] &  sr_q[2];

endmodule

// File: rtl/tdc_seq_ctrl.sv
// Trigger TDC sequencer: clears and arms the TDC, tracks Expanded_T, captures and
// range-checks the count, and returns one result per trigger over valid/ready.
// Optional calibration statistics are enabled by defining TDC_SEQ_CAL_EN.
module tdc_seq_ctrl
  import tdc_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int CLR_CYC    = 4,
  parameter int SETTLE_CYC = 3,
  parameter int TO_W       = 16,
  parameter int TO_CYC     = 50000,
  parameter int MIN_CNT    = 16,
  parameter int MAX_CNT    = 4000
) (
  input  logic             rxclk,
  input  logic             rst_n,
  input  logic             arm,
  output logic             tdc_en,
  input  logic             expanded_t,
  input  logic [CNT_W-1:0] tdc_cnt,
  output logic             busy,
  output logic [CNT_W-1:0] res_cnt,
  output logic [1:0]       res_err,
  output logic             res_valid,
  input  logic             res_ready
`ifdef TDC_SEQ_CAL_EN
  ,
  input  logic             cal_clr,
  output logic [CNT_W-1:0] cal_min,
  output logic [CNT_W-1:0] cal_max,
  output logic [15:0]      cal_n
`endif
);

  localparam logic [TO_W-1:0] CLR_LOAD    = TO_W'(CLR_CYC - 1);
  localparam logic [TO_W-1:0] SETTLE_LAST = TO_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TO_CYC - 1);

  tdc_state_e       state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [1:0]       res_err_q, res_err_d;
  logic             e_rise, e_fall;
  logic             to_hit, out_of_range;
  logic [TO_W-1:0]  cnt_inc;

  sync_edge_det u_sync (
    .clk    (rxclk),
    .rst_n  (rst_n),
    .async_i(expanded_t),
    .rise_o (e_rise),
    .fall_o (e_fall)
  );

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_cnt_q <= '0;
      res_err_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_cnt_q <= res_cnt_d;
      res_err_q <= res_err_d;
    end
  end

  assign to_hit       = (cnt_q == TO_LAST);
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign out_of_range = (tdc_cnt < CNT_W'(MIN_CNT)) || (tdc_cnt > CNT_W'(MAX_CNT));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_cnt_d = res_cnt_q;
    res_err_d = res_err_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = CLR;
          cnt_d   = CLR_LOAD;
        end
      end
      CLR: begin
        if (cnt_q == '0) begin
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_RISE: begin
        // A level already high on entry gives no rise and ends in timeout.
        if (e_rise) begin
          state_d = WAIT_FALL;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d           = DONE;
          res_cnt_d         = '0;
          res_err_d         = '0;
          res_err_d[ERR_TO] = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_FALL: begin
        if (e_fall) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d           = DONE;
          res_cnt_d         = tdc_cnt;
          res_err_d         = '0;
          res_err_d[ERR_TO] = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d              = DONE;
          cnt_d                = '0;
          res_cnt_d            = tdc_cnt;
          res_err_d            = '0;
          res_err_d[ERR_RANGE] = out_of_range;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from the state flops so reset clears the TDC at once.
  assign tdc_en    = (state_q == WAIT_RISE) || (state_q == WAIT_FALL) || (state_q == SETTLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_cnt   = res_cnt_q;
  assign res_err   = res_err_q;

`ifdef TDC_SEQ_CAL_EN
  logic [CNT_W-1:0] cal_min_q, cal_max_q;
  logic [15:0]      cal_n_q;
  logic             cal_upd;

  assign cal_upd = res_valid && res_ready && (res_err_q == 2'b00);

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      cal_min_q <= '1;
      cal_max_q <= '0;
      cal_n_q   <= '0;
    end else if (cal_clr) begin
      cal_min_q <= '1;
      cal_max_q <= '0;
      cal_n_q   <= '0;
    end else if (cal_upd) begin
      if (res_cnt_q < cal_min_q) cal_min_q <= res_cnt_q;
      if (res_cnt_q > cal_max_q) cal_max_q <= res_cnt_q;
      if (cal_n_q != 16'hFFFF)   cal_n_q   <= cal_n_q + 16'd1;
    end
  end

  assign cal_min = cal_min_q;
  assign cal_max = cal_max_q;
  assign cal_n   = cal_n_q;
`endif

endmodule

// File: doc/tdc_seq_ctrl.md
Name: tdc_seq_ctrl

Overview:
- Initiator-side sequencer for the trigger TDC in the DSO acquisition path.
- Arms the TDC by driving its enable, then tracks the returned stretched pulse (Expanded_T) through a synchronizer and waits for the width counter to settle.
- Captures the 32-bit width count, range-checks it, and hands one result per trigger to the acquisition/readout logic over a valid/ready handshake.
- Supervises the TDC with a timeout so a missing or stuck pulse never hangs acquisition.

Parameters:
CNT_W, 32, width of TDC count input and result output
CLR_CYC, 4, rxclk cycles tdc_en is held low to clear the TDC flip-flops before arming
SETTLE_CYC, 3, rxclk cycles waited after synchronized Expanded_T fall before sampling the count
TO_W, 16, timeout counter width
TO_CYC, 50000, cycles allowed in each wait state before timeout
MIN_CNT, 16, smallest legal count (inclusive)
MAX_CNT, 4000, largest legal count (inclusive)

Ports:
rxclk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  one-cycle request to start a measurement; ignored unless state is IDLE
tdc_en  out  1  TDC enable, active-high; low clears the TDC
expanded_t  in  1  stretched pulse from the analog expander; asynchronous
tdc_cnt  in  CNT_W  width count from the TDC measurement counter
busy  out  1  high in every state except IDLE
res_cnt  out  CNT_W  captured count
res_err  out  2  {range_err, timeout}
res_valid  out  1  result valid
res_ready  in  1  consumer accepts the result

Behaviour:
- Reset values: tdc_en=0, busy=0, res_cnt=0, res_err=0, res_valid=0, state=IDLE, all counters 0.
- expanded_t passes through a 2-FF synchronizer, giving e_s. Rise and fall are detected from e_s and its one-cycle delayed copy.
- FSM states:
  - IDLE: on arm, go to CLR and load the counter with CLR_CYC-1.
  - CLR: tdc_en=0. When the counter reaches 0, go to WAIT_RISE.
  - WAIT_RISE: tdc_en=1; the timeout counter runs. On rise, go to WAIT_FALL with the timeout counter zeroed. When the counter reaches TO_CYC-1, go to DONE with timeout=1 and res_cnt=0.
  - WAIT_FALL: tdc_en=1; the timeout counter runs. On fall, go to SETTLE. When the counter reaches TO_CYC-1, go to DONE with timeout=1 and res_cnt=tdc_cnt.
  - SETTLE: tdc_en=1. After SETTLE_CYC cycles, go to DONE with res_cnt=tdc_cnt. Set range_err=1 if the count is below MIN_CNT or above MAX_CNT.
  - DONE: tdc_en=0 and res_valid=1. res_cnt and res_err hold stable while res_valid is high. When res_valid and res_ready are both high on a rising edge, go to IDLE.
- Latency: from the synchronized fall to res_valid is SETTLE_CYC+1 cycles. From arm to tdc_en high is CLR_CYC+1 cycles.
- If e_s is already high on entry to WAIT_RISE, there is no rise event, so the block times out. A stuck-high expander is reported as timeout, never as a result.
- If rise and fall occur in the same cycle, this is impossible after the synchronizer by construction. A pulse shorter than 1 rxclk may be missed; that case is a timeout.
- arm while busy is ignored and not queued.
- If res_ready is high on entry to DONE, res_valid is still high for at least 1 cycle before the block returns to IDLE.
- Timeout counter saturates and never wraps.
- Range compare is unsigned on the full CNT_W.
- Asynchronous reset mid-operation: everything returns to the reset values immediately, and tdc_en drops, clearing the TDC.

Optional Feature:
- Macro TDC_SEQ_CAL_EN adds calibration statistics.
- With the macro, the block adds input cal_clr and outputs cal_min (CNT_W), cal_max (CNT_W) and cal_n (16).
  - Every accepted result with res_err=0 updates the running min, running max and sample count; cal_n saturates at 0xFFFF.
  - cal_clr, or reset, sets cal_min to all ones, cal_max to 0 and cal_n to 0.
  - If cal_clr coincides with an update, the clear wins.
- Without the macro, these ports and registers do not exist.

Decomposition:
- Shared package tdc_pkg holds:
  - the FSM state enum (IDLE, CLR, WAIT_RISE, WAIT_FALL, SETTLE, DONE);
  - the res_err bit positions (ERR_TO=0, ERR_RANGE=1);
  - default CNT_W.
- Sub-module sync_edge_det: 2-FF synchronizer plus rise/fall pulse outputs, with async active-low reset. It is reused for other DSO trigger inputs.

Test Plan:
- Nominal:
  - Stimulus: arm, expanded_t high for 200 rxclk, tdc_cnt=200 stable.
  - Required: res_valid with res_cnt=200, res_err=0. tdc_en goes high 5 cycles after arm (CLR_CYC=4) and low in DONE.
- No pulse:
  - Stimulus: arm with expanded_t held 0.
  - Required: res_valid after CLR plus 50000 cycles, res_err=01, res_cnt=0.
- Range:
  - Stimulus: tdc_cnt=10, then tdc_cnt=5000.
  - Required: res_err=10 both times. tdc_cnt=16 and tdc_cnt=4000 give res_err=00.
- Backpressure:
  - Stimulus: hold res_ready=0 for 100 cycles and pulse arm meanwhile.
  - Required: res_cnt/res_err stable, arm ignored. Return to IDLE one cycle after res_ready=1.
- Reset:
  - Stimulus: assert rst_n=0 in WAIT_FALL.
  - Required: tdc_en=0, busy=0, res_valid=0 immediately. A fresh arm after release completes normally.
- Cal (TDC_SEQ_CAL_EN defined):
  - Stimulus: counts 300, 120, 450, then an erroneous 5.
  - Required: cal_min=120, cal_max=450, cal_n=3. cal_clr sets 0xFFFFFFFF/0/0.
